// File: rtl/force_ring_drain_ctrl_pkg.sv
// Shared types and defaults for the force-ring drain sequencer.
package MD_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERR} drain_state_t;

  localparam int DRAIN_RING_LEN       = 8;
  localparam int DRAIN_QUIET_CYCLES   = 8;
  localparam int DRAIN_TIMEOUT_CYCLES = 65535;
  localparam int DRAIN_CNT_WIDTH      = 32;

endpackage

// File: rtl/force_ring_drain_ctrl_popcount.sv
// Combinational population count of the per-node force-cache write strobes.
module force_ring_popcount #(
  parameter  int RING_LEN = 8,
  localparam int PW       = $clog2(RING_LEN + 1)
) (
  input  logic [RING_LEN-1:0] bits_i,
  output logic [PW-1:0]       count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < RING_LEN; i++) begin
      count_o = count_o + PW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/force_ring_drain_ctrl.sv
// Force-phase sequencer: waits for every PE, then for a quiet ring, then pulses drain-done.
// Also counts force-cache commits (saturating) and flags a sticky timeout.
module force_ring_drain_ctrl
  import MD_pkg::*;
#(
  parameter int RING_LEN       = DRAIN_RING_LEN,
  parameter int QUIET_CYCLES   = DRAIN_QUIET_CYCLES,
  parameter int TIMEOUT_CYCLES = DRAIN_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = DRAIN_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [RING_LEN-1:0]  i_pe_done,
  input  logic [RING_LEN-1:0]  i_nb_force_valid,
  input  logic [RING_LEN-1:0]  i_ring_buf_empty,
  input  logic [RING_LEN-1:0]  i_nb_valid_ring,
  input  logic [RING_LEN-1:0]  i_force_cache_wr_valid,
  output logic                 o_busy,
  output logic                 o_drain_done,
  output logic                 o_timeout_err,
  output logic [CNT_WIDTH-1:0] o_force_count
);

  localparam int PW = $clog2(RING_LEN + 1);
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

  drain_state_t         state_q;
  logic [RING_LEN-1:0]  done_mask_q;
  logic [RING_LEN-1:0]  done_mask_d;
  logic [QW-1:0]        quiet_cnt_q;
  logic [TW-1:0]        tmo_cnt_q;
  logic [CNT_WIDTH-1:0] force_cnt_q;
  logic [CNT_WIDTH-1:0] force_cnt_d;
  logic                 busy_q;
  logic                 drain_done_q;
  logic                 timeout_err_q;

  logic [PW-1:0]        wr_pop;
  logic [SW-1:0]        force_sum;
  logic                 ring_quiet;
  logic                 tmo_hit;
  logic                 drain_hit;

  force_ring_popcount #(.RING_LEN(RING_LEN)) u_popcount (
    .bits_i  (i_force_cache_wr_valid),
    .count_o (wr_pop)
  );

  // Extra headroom bit catches the carry so the count clamps instead of wrapping.
  assign force_sum   = SW'(force_cnt_q) + SW'(wr_pop);
  assign force_cnt_d = (|force_sum[SW-1:CNT_WIDTH]) ? '1 : force_sum[CNT_WIDTH-1:0];

  assign done_mask_d = done_mask_q | i_pe_done;
  assign ring_quiet  = ~|i_nb_force_valid & ~|i_nb_valid_ring & &i_ring_buf_empty;
  assign tmo_hit     = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign drain_hit   = ring_quiet && (quiet_cnt_q == QW'(QUIET_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      done_mask_q   <= '0;
      quiet_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      force_cnt_q   <= '0;
      busy_q        <= 1'b0;
      drain_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_cnt_q <= '0;
          if (i_start) begin
            state_q       <= RUN;
            busy_q        <= 1'b1;
            done_mask_q   <= '0;
            force_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
          end
        end
        RUN: begin
          force_cnt_q <= force_cnt_d;
          done_mask_q <= done_mask_d;
          tmo_cnt_q   <= tmo_cnt_q + 1'b1;
          // A timeout on the very cycle the last PE reports still aborts the phase.
          if (tmo_hit) begin
            state_q       <= ERR;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            tmo_cnt_q     <= '0;
          end else if (&done_mask_d) begin
            state_q     <= DRAIN;
            quiet_cnt_q <= '0;
          end
        end
        DRAIN: begin
          force_cnt_q <= force_cnt_d;
          tmo_cnt_q   <= tmo_cnt_q + 1'b1;
          quiet_cnt_q <= ring_quiet ? quiet_cnt_q + 1'b1 : '0;
          if (drain_hit) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            drain_done_q <= 1'b1;
            tmo_cnt_q    <= '0;
          end else if (tmo_hit) begin
            state_q       <= ERR;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            tmo_cnt_q     <= '0;
          end
        end
        DONE: begin
          force_cnt_q <= force_cnt_d;
          state_q     <= IDLE;
        end
        ERR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy        = busy_q;
  assign o_drain_done  = drain_done_q;
  assign o_timeout_err = timeout_err_q;
  assign o_force_count = force_cnt_q;

endmodule

// File: tb/tb_force_ring_drain_ctrl.sv
// Randomized phase bench: each phase plan is scored by a cycle-level model, the monitor checks events.
module tb_force_ring_drain_ctrl;

  localparam int RL = 8;
  localparam int QC = 8;
  localparam int TC = 64;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic i_start;
  logic [RL-1:0] i_pe_done, i_nb_force_valid, i_ring_buf_empty, i_nb_valid_ring, i_force_cache_wr_valid;
  logic o_busy, o_drain_done, o_timeout_err;
  logic [CW-1:0] o_force_count;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit            is_err;
    int            start_cyc;
    int            evt_rel;
    logic [CW-1:0] count;
  } exp_t;
  exp_t exp_q[$];

  logic [RL-1:0] a_pe[128], a_nbf[128], a_nbr[128], a_bufe[128], a_wr[128];
  bit            a_st[128];

  force_ring_drain_ctrl #(
    .RING_LEN(RL), .QUIET_CYCLES(QC), .TIMEOUT_CYCLES(TC), .CNT_WIDTH(CW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_start                (i_start),
    .i_pe_done              (i_pe_done),
    .i_nb_force_valid       (i_nb_force_valid),
    .i_ring_buf_empty       (i_ring_buf_empty),
    .i_nb_valid_ring        (i_nb_valid_ring),
    .i_force_cache_wr_valid (i_force_cache_wr_valid),
    .o_busy                 (o_busy),
    .o_drain_done           (o_drain_done),
    .o_timeout_err          (o_timeout_err),
    .o_force_count          (o_force_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 50000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    i_start = 1'b0;
    i_pe_done = RL'($urandom);
    i_nb_force_valid = '0;
    i_nb_valid_ring = '0;
    i_ring_buf_empty = '1;
    i_force_cache_wr_valid = RL'($urandom);
  endtask

  task automatic add_noise(input int k);
    case ($urandom_range(0, 2))
      0: a_nbf[k][$urandom_range(0, RL-1)] = 1'b1;
      1: a_nbr[k][$urandom_range(0, RL-1)] = 1'b1;
      default: a_bufe[k][$urandom_range(0, RL-1)] = 1'b0;
    endcase
  endtask

  // mode 0-2 normal, 3 last PE never done, 4 drain completes on the timeout cycle, 5 misses it by one
  task automatic run_phase(input int mode);
    int off, dmax, d_all, run, k_evt, last, sum, style, k;
    bit is_err;
    exp_t e;
    style = $urandom_range(0, 3);
    for (int i = 0; i < 128; i++) begin
      a_pe[i] = '0; a_nbf[i] = '0; a_nbr[i] = '0; a_bufe[i] = '1; a_st[i] = 1'b0;
      case (style)
        0, 1:    a_wr[i] = RL'($urandom & $urandom);
        2:       a_wr[i] = RL'($urandom);
        default: a_wr[i] = '1;
      endcase
      if (i >= 1 && i <= 34 && $urandom_range(0, 5) == 0) add_noise(i);
    end
    a_st[0] = 1'b1;
    a_pe[0] = RL'($urandom);  // raised while still idle: must not count
    dmax = 0;
    for (int j = 0; j < RL; j++) begin
      if (!(mode == 3 && j == RL-1)) begin
        off = $urandom_range(0, 12);
        a_pe[1+off][j] = 1'b1;
        if (off > dmax) dmax = off;
      end
    end
    d_all = (mode == 3) ? 1000 : 1 + dmax;
    if (mode == 4 || mode == 5) begin
      last = (mode == 4) ? TC - QC : TC - QC + 1;
      for (int i = d_all + 1; i < 128; i++) begin
        a_nbf[i] = '0; a_nbr[i] = '0; a_bufe[i] = '1;
      end
      k = d_all + 1;
      while (k < last) begin
        add_noise(k);
        k += $urandom_range(1, QC-1);
      end
      add_noise(last);
    end

    // Reference: cycle k of the phase is k cycles after the start strobe; the phase may
    // run for TC cycles (1..TC), and QC consecutive quiet cycles after all-done end it.
    is_err = 1'b1;
    k_evt  = TC + 1;
    run    = 0;
    for (int i = d_all + 1; i <= TC; i++) begin
      if (a_nbf[i] == '0 && a_nbr[i] == '0 && a_bufe[i] == '1) run++;
      else run = 0;
      if (run == QC) begin
        is_err = 1'b0;
        k_evt  = i + 1;
        break;
      end
    end
    sum = 0;
    for (int i = 1; i <= (is_err ? TC : k_evt); i++) sum += $countones(a_wr[i]);
    if (sum > CMAX) sum = CMAX;
    for (int i = 2; i < k_evt; i++) if ($urandom_range(0, 9) == 0) a_st[i] = 1'b1;

    e.is_err  = is_err;
    e.evt_rel = k_evt;
    e.count   = CW'(sum);
    for (int i = 0; i <= k_evt; i++) begin
      @(posedge clk); #1;
      i_start = a_st[i];
      i_pe_done = a_pe[i];
      i_nb_force_valid = a_nbf[i];
      i_nb_valid_ring = a_nbr[i];
      i_ring_buf_empty = a_bufe[i];
      i_force_cache_wr_valid = a_wr[i];
      if (i == 0) begin
        e.start_cyc = cyc;
        exp_q.push_back(e);
      end
    end
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
      drive_idle();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t e;
    bit prev_busy, prev_err;
    int busy_rise;
    prev_busy = 1'b0;
    prev_err  = 1'b0;
    busy_rise = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        prev_err  = 1'b0;
        busy_rise = -1;
      end else begin
        if (o_busy && !prev_busy) begin
          busy_rise = cyc;
          check("err_cleared_by_start", o_timeout_err, 1'b0);
        end
        if (o_drain_done || (o_timeout_err && !prev_err)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("drain_pulse", o_drain_done, !e.is_err);
            check("timeout_flag", o_timeout_err, e.is_err);
            check("event_cycle", cyc - e.start_cyc, e.evt_rel);
            check("busy_rise", busy_rise - e.start_cyc, 1);
            check("busy_fall", {prev_busy, o_busy}, 2'b10);
            @(negedge clk);
            check("force_count", o_force_count, e.count);
            check("drain_pulse_width", o_drain_done, 1'b0);
            check("err_sticky", o_timeout_err, e.is_err);
          end
        end
        prev_busy = o_busy;
        prev_err  = o_timeout_err;
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin : stimulus
    rst = 1'b1;
    drive_idle();
    i_pe_done = '0;
    i_force_cache_wr_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", o_busy, 1'b0);
    check("reset_drain_done", o_drain_done, 1'b0);
    check("reset_timeout_err", o_timeout_err, 1'b0);
    check("reset_force_count", o_force_count, '0);

    run_phase(0);
    run_phase(3);
    run_phase(4);
    run_phase(5);
    for (int p = 0; p < 30; p++) run_phase($urandom_range(0, 5));

    // Reset in the middle of DRAIN: no pulse, everything back to zero.
    @(posedge clk); #1;
    i_start = 1'b1; i_pe_done = '0; i_force_cache_wr_valid = '1;
    @(posedge clk); #1;
    i_start = 1'b0; i_pe_done = '1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_pe_done = '0;
    i_force_cache_wr_valid = '0;
    @(negedge clk);
    check("rst_mid_busy", o_busy, 1'b0);
    check("rst_mid_timeout_err", o_timeout_err, 1'b0);
    check("rst_mid_force_count", o_force_count, '0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("rst_mid_still_idle", {o_busy, o_drain_done}, 2'b00);

    run_phase(0);
    run_phase(3);
    run_phase(0);

    repeat (4) @(posedge clk);
    check("events_outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
